vga_dac_pixel_engine: RTL
=========================

Name: vga_dac_pixel_engine

Overview:
Parametrised pixel engine that replaces the fixed 3x8-bit controller feeding the current-steering DACs. It generates VGA timing, produces NCH channel codes of DW bits each from one of four test-pattern modes, and drives per-channel DAC bias codes. Mode and bias are loaded over a synchronised serial config port and take effect at frame boundaries, so switching never tears a frame. It sits between the TT pin interface and the csdac instances.

Parameters:
NCH, 3, number of DAC channels
DW, 8, DAC data width per channel
BW, 3, bias code width per channel
BIAS_RST, 3'b100, reset bias code applied to every channel
H_ACTIVE/H_FP/H_SYNC/H_BP, 640/16/96/48, horizontal timing in clocks
V_ACTIVE/V_FP/V_SYNC/V_BP, 480/10/2/33, vertical timing in lines
SYNC_POL, 0, active level of hsync/vsync
BAR_SHIFT, 6, log2 of colour-bar width in pixels
CFG_W, 2+NCH*BW, config frame length in bits (derived, not overridable)

Ports:
clk  in  1  pixel clock
rst  in  1  asynchronous active-high reset
ena  in  1  advance enable; when 0, counters and config sampling hold
cfg_sclk  in  1  serial config clock (asynchronous, oversampled)
cfg_sdi  in  1  serial config data, MSB first
cfg_csn  in  1  serial config frame select, active low
hsync  out  1  horizontal sync, level SYNC_POL when active
vsync  out  1  vertical sync
de  out  1  active-video flag
data  out  NCH*DW  channel codes, channel c at [c*DW +: DW]
bias  out  NCH*BW  channel bias codes, channel c at [c*BW +: BW]
frame  out  8  frame counter, wraps 255->0
cfg_err  out  1  sticky: last frame had a wrong bit count; cleared by next good commit

Behaviour:
- Reset (async assert, sync release): x=y=0, frame=0, data=0, de=0, hsync=vsync=~SYNC_POL, bias=BIAS_RST for all channels, mode=0, shadow regs equal active, cfg_err=0.
- Counters: x runs 0..H_TOTAL-1, then wraps and y increments; y wraps after V_TOTAL-1 and frame increments. Active region is x<H_ACTIVE and y<V_ACTIVE. Sync is asserted when x (or y) lies in [ACTIVE+FP, ACTIVE+FP+SYNC).
- Latency: all outputs are registered; hsync/vsync/de/data reflect the counter state from one cycle earlier, so they stay mutually aligned.
- Pattern selection, with de=1; when de=0 all data is 0:
  - mode0 gradient: ch0=x[DW-1:0]; ch1=y[DW-1:0]; ch c>=2: ((x^y)+frame)[DW-1:0].
  - mode1 bars: b=x[BAR_SHIFT+2:BAR_SHIFT]; ch c is all-ones if b[c%3] is set, else 0.
  - mode2 checker: every channel is {DW{x[4]^y[4]}}.
  - mode3 solid: every channel is all-ones.
- Config port:
  - cfg_* pass through 2-flop synchronisers; a rising edge on synced sclk while csn is low shifts sdi into a CFG_W-bit shift register and bumps a bit counter, which saturates at CFG_W+1.
  - On a synced csn rising edge: if count==CFG_W, shadow gets {mode[1:0], bias ch NCH-1..0} and cfg_err is cleared; otherwise shadow is unchanged and cfg_err is set.
  - A csn falling edge clears the count.
  - Edges that arrive while ena=0 are lost.
- Frame-boundary apply: when counters wrap to (0,0), the active mode and bias load from shadow. If a commit coincides with the wrap cycle, the old shadow is applied and the new value waits for the next frame.
- Reset asserted mid-frame or mid-shift: everything returns to reset values immediately and any partial frame is discarded.

Decomposition:
- Package vga_dac_pkg holds: the mode enum (MODE_GRAD, MODE_BARS, MODE_CHECK, MODE_SOLID), default timing constants, and the H_TOTAL/V_TOTAL derivation functions.
- Sub-module vga_cfg_shift covers synchronisers, edge detect, shift register, bit counter and shadow register with cfg_err; it outputs shadow_mode and shadow_bias.
- Timing, pattern logic and output registers stay in the top.

Test Plan:
Bench uses H 16/2/2/2, V 8/1/1/1, NCH=3, DW=8, SYNC_POL=0.
- Reset release -> hsync=vsync=1, de=0, data=0, bias=0x124 (3x 3'b100); first de rises 1 cycle after x=0,y=0 counter state.
- Timing: run 2 frames -> line period 22 clks, hsync low exactly at x=18..19, vsync low for 1 line at y=9, frame reads 2.
- mode0 at frame 0, pixel (5,3) -> ch0=0x05, ch1=0x03, ch2=0x06; all channels 0 during blanking.
- Serial write of 11 bits: mode=01, bias 3'b111/3'b010/3'b001 (ch2..ch0) -> no change mid-frame; at next (0,0) bias=0x1D1 and the bar pattern appears; cfg_err=0.
- Serial write of 10 bits then csn high -> shadow unchanged, cfg_err=1; next good 11-bit write clears it.
- Commit landing on the wrap cycle -> the new mode is not visible in that frame but is in the following one; async rst pulse mid-shift -> all reset values, and the partial frame is not applied.

Source files
------------

// File: rtl/vga_dac_pkg.sv
// Shared types and timing defaults for the VGA DAC pixel engine.
package vga_dac_pkg;

    typedef enum logic [1:0] {
        MODE_GRAD  = 2'd0,
        MODE_BARS  = 2'd1,
        MODE_CHECK = 2'd2,
        MODE_SOLID = 2'd3
    } mode_e;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    function automatic int h_total(int active, int fp, int sync, int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int v_total(int active, int fp, int sync, int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_cfg_shift.sv
// Serial config receiver: synchronises the slow port, shifts a frame in and
// commits it to the shadow registers on csn release when the length is right.
module vga_cfg_shift
    import vga_dac_pkg::*;
#(
    parameter int            NCH      = 3,
    parameter int            BW       = 3,
    parameter logic [BW-1:0] BIAS_RST = 'b100
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ena,
    input  logic                cfg_sclk,
    input  logic                cfg_sdi,
    input  logic                cfg_csn,
    output mode_e               shadow_mode,
    output logic [NCH*BW-1:0]   shadow_bias,
    output logic                cfg_err
);

    localparam int CFG_W = 2 + NCH * BW;
    localparam int CNT_W = $clog2(CFG_W + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_W);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CFG_W + 1);

    // [1] is the synchronised level, [2] its previous value for edge detect
    logic [2:0]       sclk_p;
    logic [2:0]       csn_p;
    logic [1:0]       sdi_p;
    logic [CFG_W-1:0] sr;
    logic [CNT_W-1:0] cnt;

    logic sclk_rise, csn_rise, csn_fall;
    assign sclk_rise = sclk_p[1] & ~sclk_p[2];
    assign csn_rise  = csn_p[1] & ~csn_p[2];
    assign csn_fall  = ~csn_p[1] & csn_p[2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_p      <= '0;
            csn_p       <= '1;
            sdi_p       <= '0;
            sr          <= '0;
            cnt         <= '0;
            shadow_mode <= MODE_GRAD;
            shadow_bias <= {NCH{BIAS_RST}};
            cfg_err     <= 1'b0;
        end else begin
            sclk_p <= {sclk_p[1:0], cfg_sclk};
            csn_p  <= {csn_p[1:0], cfg_csn};
            sdi_p  <= {sdi_p[0], cfg_sdi};
            // Synchronisers keep running while held, so edges seen then are dropped
            if (ena) begin
                if (csn_fall) begin
                    cnt <= '0;
                end else if (sclk_rise && !csn_p[1]) begin
                    sr <= {sr[CFG_W-2:0], sdi_p[1]};
                    if (cnt != CNT_SAT) cnt <= cnt + CNT_W'(1);
                end
                if (csn_rise) begin
                    if (cnt == CNT_FULL) begin
                        shadow_mode <= mode_e'(sr[CFG_W-1 -: 2]);
                        shadow_bias <= sr[NCH*BW-1:0];
                        cfg_err     <= 1'b0;
                    end else begin
                        cfg_err <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/vga_dac_pixel_engine.sv
// VGA timing, test-pattern generation and per-channel DAC bias, with config
// changes applied only at the frame wrap.
module vga_dac_pixel_engine
    import vga_dac_pkg::*;
#(
    parameter int            NCH       = 3,
    parameter int            DW        = 8,
    parameter int            BW        = 3,
    parameter logic [BW-1:0] BIAS_RST  = 'b100,
    parameter int            H_ACTIVE  = H_ACTIVE_DEF,
    parameter int            H_FP      = H_FP_DEF,
    parameter int            H_SYNC    = H_SYNC_DEF,
    parameter int            H_BP      = H_BP_DEF,
    parameter int            V_ACTIVE  = V_ACTIVE_DEF,
    parameter int            V_FP      = V_FP_DEF,
    parameter int            V_SYNC    = V_SYNC_DEF,
    parameter int            V_BP      = V_BP_DEF,
    parameter logic          SYNC_POL  = 1'b0,
    parameter int            BAR_SHIFT = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ena,
    input  logic                cfg_sclk,
    input  logic                cfg_sdi,
    input  logic                cfg_csn,
    output logic                hsync,
    output logic                vsync,
    output logic                de,
    output logic [NCH*DW-1:0]   data,
    output logic [NCH*BW-1:0]   bias,
    output logic [7:0]          frame,
    output logic                cfg_err
);

    localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int XW = $clog2(H_TOTAL);
    localparam int YW = $clog2(V_TOTAL);

    localparam logic [XW-1:0] X_LAST = XW'(H_TOTAL - 1);
    localparam logic [XW-1:0] X_ACT  = XW'(H_ACTIVE);
    localparam logic [XW-1:0] HS_ON  = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0] HS_OFF = XW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [YW-1:0] Y_LAST = YW'(V_TOTAL - 1);
    localparam logic [YW-1:0] Y_ACT  = YW'(V_ACTIVE);
    localparam logic [YW-1:0] VS_ON  = YW'(V_ACTIVE + V_FP);
    localparam logic [YW-1:0] VS_OFF = YW'(V_ACTIVE + V_FP + V_SYNC);

    logic [XW-1:0]              x;
    logic [YW-1:0]              y;
    mode_e                      mode, shadow_mode;
    logic [NCH*BW-1:0]          shadow_bias;
    logic [NCH-1:0][DW-1:0]     pix, data_q;

    vga_cfg_shift #(
        .NCH      (NCH),
        .BW       (BW),
        .BIAS_RST (BIAS_RST)
    ) u_cfg (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .cfg_sclk    (cfg_sclk),
        .cfg_sdi     (cfg_sdi),
        .cfg_csn     (cfg_csn),
        .shadow_mode (shadow_mode),
        .shadow_bias (shadow_bias),
        .cfg_err     (cfg_err)
    );

    logic act, hs_on, vs_on, x_last, y_last, chk;
    logic [2:0] bar;
    assign act    = (x < X_ACT) && (y < Y_ACT);
    assign hs_on  = (x >= HS_ON) && (x < HS_OFF);
    assign vs_on  = (y >= VS_ON) && (y < VS_OFF);
    assign x_last = (x == X_LAST);
    assign y_last = (y == Y_LAST);
    assign bar    = 3'(x >> BAR_SHIFT);
    assign chk    = 1'(x >> 4) ^ 1'(y >> 4);

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [DW-1:0] p;
        always_comb begin
            p = '0;
            case (mode)
                MODE_GRAD:  p = (c == 0) ? DW'(x) :
                                (c == 1) ? DW'(y) :
                                (DW'(x) ^ DW'(y)) + DW'(frame);
                MODE_BARS:  p = {DW{bar[c % 3]}};
                MODE_CHECK: p = {DW{chk}};
                MODE_SOLID: p = '1;
                default:    p = '0;
            endcase
        end
        assign pix[c] = p;
    end

    assign data = data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x      <= '0;
            y      <= '0;
            frame  <= '0;
            mode   <= MODE_GRAD;
            bias   <= {NCH{BIAS_RST}};
            hsync  <= ~SYNC_POL;
            vsync  <= ~SYNC_POL;
            de     <= 1'b0;
            data_q <= '0;
        end else begin
            // Outputs always describe the counter state of the previous cycle
            hsync  <= hs_on ? SYNC_POL : ~SYNC_POL;
            vsync  <= vs_on ? SYNC_POL : ~SYNC_POL;
            de     <= act;
            data_q <= act ? pix : '0;
            if (ena) begin
                if (x_last) begin
                    x <= '0;
                    if (y_last) begin
                        // A commit on this same edge lands in shadow only, so it waits a frame
                        y     <= '0;
                        frame <= frame + 8'd1;
                        mode  <= shadow_mode;
                        bias  <= shadow_bias;
                    end else begin
                        y <= y + YW'(1);
                    end
                end else begin
                    x <= x + XW'(1);
                end
            end
        end
    end

endmodule
